// File: rtl/carfield_mailbox_pkg.sv
// Shared definitions for the mailbox responder.
//   - Register word indices inside one mailbox (byte offset / 4).
//   - mbox_state_t: architectural state of a single mailbox.
//   - rsp_fsm_e: request/response handshake states.
//   - merge_bytes: byte-strobed write merge.
package carfield_mailbox_pkg;

    localparam logic [2:0] REG_LETTER0  = 3'd0;  // 0x00
    localparam logic [2:0] REG_LETTER1  = 3'd1;  // 0x04
    localparam logic [2:0] REG_DOORBELL = 3'd2;  // 0x08
    localparam logic [2:0] REG_ACK      = 3'd3;  // 0x0C
    localparam logic [2:0] REG_DONE     = 3'd4;  // 0x10
    localparam logic [2:0] REG_IRQ_EN   = 3'd5;  // 0x14

    // Bytes at the start of each mailbox slot that can hold registers;
    // anything beyond this inside a wider stride is unmapped.
    localparam int unsigned REG_SPAN = 32;

    typedef struct packed {
        logic [31:0] letter0;
        logic [31:0] letter1;
        logic        pending;
        logic        done;
        logic [1:0]  irq_en;   // bit0 doorbell, bit1 done
    } mbox_state_t;

    typedef enum logic {
        IDLE,
        RESP
    } rsp_fsm_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/carfield_mailbox_responder_if.sv
// Single-beat register request/response bus into the mailbox window.
//   master: initiator (drives req_*, rsp_ready)
//   slave : responder (drives req_ready, rsp_*)
interface carfield_mailbox_responder_if #(
    parameter int unsigned AddrWidth = 48
);
    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;
    logic                 req_write;
    logic [31:0]          req_wdata;
    logic [3:0]           req_wstrb;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_error;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/carfield_mailbox_slot.sv
// One mailbox: two letter words, doorbell/ack/done handshake, irq enables
// and the two registered interrupt outputs.
//   clk_i, rst_i        clock, asynchronous active-high reset
//   acc_i               accepted access targeting this mailbox (address legal)
//   write_i             1 = write
//   reg_idx_i           register word index within the mailbox
//   wdata_i, wstrb_i    write data and byte strobes
//   rdata_o, error_o    combinational read data / access error for reg_idx_i
//   doorbell_irq_o      q(pending & irq_en[0])
//   done_irq_o          q(done & irq_en[1])
module carfield_mailbox_slot
    import carfield_mailbox_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        acc_i,
    input  logic        write_i,
    input  logic [2:0]  reg_idx_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        error_o,
    output logic        doorbell_irq_o,
    output logic        done_irq_o
);

    mbox_state_t st;
    logic        ctrl_set;

    // Control registers only act on bit 0 with byte lane 0 enabled.
    assign ctrl_set = wstrb_i[0] & wdata_i[0];

    always_comb begin
        rdata_o = '0;
        error_o = 1'b0;
        case (reg_idx_i)
            REG_LETTER0:  rdata_o = st.letter0;
            REG_LETTER1:  rdata_o = st.letter1;
            REG_DOORBELL: rdata_o = {31'b0, st.pending};
            // Write-only; acknowledging with nothing pending is refused.
            REG_ACK:      error_o = ~write_i | (ctrl_set & ~st.pending);
            REG_DONE:     rdata_o = {31'b0, st.done};
            REG_IRQ_EN:   rdata_o = {30'b0, st.irq_en};
            default:      error_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st             <= '0;
            doorbell_irq_o <= 1'b0;
            done_irq_o     <= 1'b0;
        end else begin
            doorbell_irq_o <= st.pending & st.irq_en[0];
            done_irq_o     <= st.done & st.irq_en[1];
            if (acc_i && write_i && !error_o) begin
                case (reg_idx_i)
                    REG_LETTER0:  st.letter0 <= merge_bytes(st.letter0, wdata_i, wstrb_i);
                    REG_LETTER1:  st.letter1 <= merge_bytes(st.letter1, wdata_i, wstrb_i);
                    REG_DOORBELL: if (ctrl_set) begin
                        st.pending <= 1'b1;
                        st.done    <= 1'b0;
                    end
                    REG_ACK:      if (ctrl_set) begin
                        st.pending <= 1'b0;
                        st.done    <= 1'b1;
                    end
                    REG_DONE:     if (ctrl_set) st.done <= 1'b0;
                    REG_IRQ_EN:   if (wstrb_i[0]) st.irq_en <= wdata_i[1:0];
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: rtl/carfield_mailbox_responder.sv
// Responder side of the inter-domain mailbox window.
// Decodes single-beat 32-bit accesses into NumMbox mailboxes, answers each
// with a registered response one cycle after acceptance, and exposes the
// per-mailbox doorbell and done interrupts.
//   clk_i, rst_i     clock, asynchronous active-high reset
//   bus              request/response bus (slave side)
//   doorbell_irq_o   per-mailbox doorbell interrupt
//   done_irq_o       per-mailbox done interrupt
module carfield_mailbox_responder
    import carfield_mailbox_pkg::*;
#(
    parameter int unsigned          AddrWidth  = 48,
    parameter int unsigned          NumMbox    = 8,
    parameter logic [AddrWidth-1:0] MboxBase   = 48'h0000_4000_0000,
    parameter logic [AddrWidth-1:0] MboxSize   = 48'h0000_0000_1000,
    parameter int unsigned          MboxStride = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    carfield_mailbox_responder_if.slave  bus,
    output logic [NumMbox-1:0]           doorbell_irq_o,
    output logic [NumMbox-1:0]           done_irq_o
);

    localparam int unsigned          StrideLog   = $clog2(MboxStride);
    localparam logic [AddrWidth:0]   MboxEndWide = {1'b0, MboxBase} + {1'b0, MboxSize};
    localparam logic [AddrWidth-1:0] MboxEnd     = MboxEndWide[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] StrideMask  = AddrWidth'(MboxStride - 1);

    if (MboxEndWide[AddrWidth]) begin : g_bad_window
        $error("mailbox window wraps past the top of the address space");
    end
    if (NumMbox < 1 || NumMbox > 16) begin : g_bad_num
        $error("NumMbox must be in 1..16");
    end
    if (MboxStride < 32 || (1 << StrideLog) != MboxStride) begin : g_bad_stride
        $error("MboxStride must be a power of two >= 32");
    end

    rsp_fsm_e             state_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_error_q;

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] mbox_idx;
    logic [AddrWidth-1:0] reg_off;
    logic [2:0]           reg_idx;
    logic                 addr_err;
    logic                 accept;
    logic [NumMbox-1:0]   hit;
    logic [31:0]          slot_rdata [NumMbox];
    logic [NumMbox-1:0]   slot_err;
    logic [31:0]          sel_rdata;
    logic                 sel_err;
    logic                 acc_err;

    assign off      = bus.req_addr - MboxBase;
    assign mbox_idx = off >> StrideLog;
    assign reg_off  = off & StrideMask;
    assign reg_idx  = reg_off[4:2];
    assign accept   = req_ready_q & bus.req_valid;

    assign addr_err = (bus.req_addr < MboxBase)
                    | (bus.req_addr >= MboxEnd)
                    | (bus.req_addr[1:0] != 2'b00)
                    | (mbox_idx >= AddrWidth'(NumMbox))
                    | (reg_off >= AddrWidth'(REG_SPAN));

    for (genvar i = 0; i < NumMbox; i++) begin : g_slot
        assign hit[i] = (mbox_idx == AddrWidth'(i));

        carfield_mailbox_slot u_slot (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .acc_i          (accept & ~addr_err & hit[i]),
            .write_i        (bus.req_write),
            .reg_idx_i      (reg_idx),
            .wdata_i        (bus.req_wdata),
            .wstrb_i        (bus.req_wstrb),
            .rdata_o        (slot_rdata[i]),
            .error_o        (slot_err[i]),
            .doorbell_irq_o (doorbell_irq_o[i]),
            .done_irq_o     (done_irq_o[i])
        );
    end

    // At most one slot matches; an out-of-range index matches none and is
    // already flagged by addr_err.
    always_comb begin
        sel_rdata = '0;
        sel_err   = 1'b0;
        for (int i = 0; i < NumMbox; i++) begin
            if (hit[i]) begin
                sel_rdata = slot_rdata[i];
                sel_err   = slot_err[i];
            end
        end
    end

    assign acc_err = addr_err | sel_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    state_q     <= RESP;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= acc_err;
                    rsp_rdata_q <= (acc_err || bus.req_write) ? 32'h0 : sel_rdata;
                end
                RESP: if (bus.rsp_ready) begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_error_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_carfield_mailbox_responder.sv
// Bench for carfield_mailbox_responder: directed scenarios plus randomized
// accesses, each compared against a register-level model of the mailboxes.
module tb_carfield_mailbox_responder;

    localparam logic [47:0] BASE   = 48'h0000_4000_0000;
    localparam logic [47:0] SIZE   = 48'h0000_0000_1000;
    localparam int          NUM    = 8;
    localparam int          STRIDE = 32;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [NUM-1:0] doorbell_irq;
    logic [NUM-1:0] done_irq;

    carfield_mailbox_responder_if #(.AddrWidth(48)) bus ();

    carfield_mailbox_responder #(
        .AddrWidth (48),
        .NumMbox   (NUM),
        .MboxBase  (BASE),
        .MboxSize  (SIZE),
        .MboxStride(STRIDE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .bus           (bus),
        .doorbell_irq_o(doorbell_irq),
        .done_irq_o    (done_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0]    m_l0   [16];
    logic [31:0]    m_l1   [16];
    logic           m_pend [16];
    logic           m_done [16];
    logic [1:0]     m_en   [16];
    logic [NUM-1:0] exp_db;
    logic [NUM-1:0] exp_dn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] strobe_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                                 input logic [3:0] ws);
        logic [31:0] mask;
        mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_update_irqs();
        for (int i = 0; i < NUM; i++) begin
            exp_db[i] = m_pend[i] & m_en[i][0];
            exp_dn[i] = m_done[i] & m_en[i][1];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_l0[i] = '0; m_l1[i] = '0; m_pend[i] = 1'b0; m_done[i] = 1'b0; m_en[i] = '0;
        end
        model_update_irqs();
    endtask

    task automatic model_access(input logic [47:0] addr, input logic wr, input logic [31:0] wd,
                                input logic [3:0] ws, output logic [31:0] rd, output logic er);
        logic [47:0] off;
        int          idx;
        int          r;
        logic        go;
        rd = '0;
        er = 1'b0;
        if (addr < BASE || addr >= BASE + SIZE || (addr % 4) != 0) begin
            er = 1'b1;
            return;
        end
        off = addr - BASE;
        idx = int'(off / STRIDE);
        r   = int'(off % STRIDE);
        if (idx >= NUM) begin
            er = 1'b1;
            return;
        end
        go = ws[0] && wd[0];
        case (r)
            'h00: if (wr) m_l0[idx] = strobe_write(m_l0[idx], wd, ws); else rd = m_l0[idx];
            'h04: if (wr) m_l1[idx] = strobe_write(m_l1[idx], wd, ws); else rd = m_l1[idx];
            'h08: if (wr) begin
                      if (go) begin m_pend[idx] = 1'b1; m_done[idx] = 1'b0; end
                  end else rd = {31'b0, m_pend[idx]};
            'h0C: if (!wr) er = 1'b1;
                  else if (go) begin
                      if (m_pend[idx]) begin m_pend[idx] = 1'b0; m_done[idx] = 1'b1; end
                      else er = 1'b1;
                  end
            'h10: if (wr) begin
                      if (go) m_done[idx] = 1'b0;
                  end else rd = {31'b0, m_done[idx]};
            'h14: if (wr) begin
                      if (ws[0]) m_en[idx] = wd[1:0];
                  end else rd = {30'b0, m_en[idx]};
            default: er = 1'b1;
        endcase
        model_update_irqs();
    endtask

    // One complete access with rsp_ready held high; checks latency, response
    // and the one-cycle lag of the interrupt outputs.
    task automatic do_access(input logic [47:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] ws, output logic [31:0] rd, output logic er);
        logic [31:0]    exp_rd;
        logic           exp_er;
        logic [NUM-1:0] prev_db;
        logic [NUM-1:0] prev_dn;
        prev_db = exp_db;
        prev_dn = exp_dn;
        model_access(addr, wr, wd, ws, exp_rd, exp_er);
        @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rsp_valid_lat1", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_error", 32'(bus.rsp_error), 32'(exp_er));
        chk("doorbell_irq_lag", 32'(doorbell_irq), 32'(prev_db));
        chk("done_irq_lag", 32'(done_irq), 32'(prev_dn));
        rd = bus.rsp_rdata;
        er = bus.rsp_error;
        @(posedge clk);
        #1;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("doorbell_irq", 32'(doorbell_irq), 32'(exp_db));
        chk("done_irq", 32'(done_irq), 32'(exp_dn));
        bus.rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        logic [47:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp_rd;
        logic        exp_er;

        rst_i         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_db_irq", 32'(doorbell_irq), 32'd0);
        chk("rst_dn_irq", 32'(done_irq), 32'd0);
        rst_i = 1'b0;

        // First read after reset
        do_access(48'h4000_0000, 1'b0, 32'h0, 4'h0, rd, er);
        chk("first_read_rdata", rd, 32'h0);

        // Byte-strobed letter write and readback
        do_access(48'h4000_0040, 1'b1, 32'hDEADBEEF, 4'b0101, rd, er);
        chk("letter_wr_rdata0", rd, 32'h0);
        do_access(48'h4000_0040, 1'b0, 32'h0, 4'h0, rd, er);
        chk("letter_strobe", rd, 32'h00AD00EF);

        // Doorbell / ack / done handshake on mbox1
        do_access(48'h4000_0034, 1'b1, 32'h3, 4'hF, rd, er);
        do_access(48'h4000_0028, 1'b1, 32'h1, 4'hF, rd, er);
        chk("mb1_db_irq_set", 32'(doorbell_irq[1]), 32'd1);
        do_access(48'h4000_0028, 1'b1, 32'h1, 4'hF, rd, er);
        chk("mb1_db_again_err", 32'(er), 32'd0);
        do_access(48'h4000_002C, 1'b1, 32'h1, 4'hF, rd, er);
        chk("mb1_ack_db_irq", 32'(doorbell_irq[1]), 32'd0);
        chk("mb1_ack_dn_irq", 32'(done_irq[1]), 32'd1);
        do_access(48'h4000_0030, 1'b0, 32'h0, 4'h0, rd, er);
        chk("mb1_done_read", rd, 32'h1);
        do_access(48'h4000_0030, 1'b1, 32'h1, 4'hF, rd, er);
        chk("mb1_done_clr_irq", 32'(done_irq[1]), 32'd0);

        // Illegal ACK cases on mbox0
        do_access(48'h4000_000C, 1'b1, 32'h1, 4'hF, rd, er);
        chk("ack_not_pending_err", 32'(er), 32'd1);
        do_access(48'h4000_0010, 1'b0, 32'h0, 4'h0, rd, er);
        chk("ack_err_done_still0", rd, 32'h0);
        do_access(48'h4000_000C, 1'b0, 32'h0, 4'h0, rd, er);
        chk("ack_read_err", 32'(er), 32'd1);
        chk("ack_read_rdata", rd, 32'h0);

        // Out-of-window, misaligned and index-out-of-range accesses
        do_access(48'h4000_1000, 1'b0, 32'h0, 4'h0, rd, er);
        chk("err_above_window", 32'(er), 32'd1);
        do_access(48'h3FFF_FFFC, 1'b0, 32'h0, 4'h0, rd, er);
        chk("err_below_window", 32'(er), 32'd1);
        do_access(48'h4000_0002, 1'b0, 32'h0, 4'h0, rd, er);
        chk("err_misaligned", 32'(er), 32'd1);
        do_access(48'h4000_0100, 1'b0, 32'h0, 4'h0, rd, er);
        chk("err_index_range", 32'(er), 32'd1);

        // Response back-pressure: hold rsp_ready low for 5 cycles
        model_access(48'h4000_0040, 1'b0, 32'h0, 4'h0, exp_rd, exp_er);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 48'h4000_0040;
        bus.req_write = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("stall_rsp_error", 32'(bus.rsp_error), 32'(exp_er));
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stall_release_ready", 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            a = BASE + 48'($urandom_range(0, 9) * STRIDE) + 48'($urandom_range(0, 8) * 4);
            case ($urandom_range(0, 15))
                0: a = a + 48'($urandom_range(1, 3));
                1: a = BASE - 48'($urandom_range(1, 16) * 4);
                2: a = BASE + SIZE + 48'($urandom_range(0, 16) * 4);
                3: a = BASE + 48'($urandom_range(0, 1023) * 4);
                default: ;
            endcase
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
            ws = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) ws[0] = 1'b1;
            do_access(a, 1'($urandom_range(0, 1)), wd, ws, rd, er);
        end

        // Set up live state on mbox3, then reset in the middle of a response
        do_access(48'h4000_0060, 1'b1, 32'h1234_5678, 4'hF, rd, er);
        do_access(48'h4000_0074, 1'b1, 32'h3, 4'hF, rd, er);
        do_access(48'h4000_0068, 1'b1, 32'h1, 4'hF, rd, er);
        chk("pre_rst_db_irq", 32'(doorbell_irq[3]), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 48'h4000_0060;
        bus.req_write = 1'b0;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("midrst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("midrst_db_irq", 32'(doorbell_irq), 32'd0);
        chk("midrst_dn_irq", 32'(done_irq), 32'd0);
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
        do_access(48'h4000_0060, 1'b0, 32'h0, 4'h0, rd, er);
        chk("post_rst_letter", rd, 32'h0);
        do_access(48'h4000_0068, 1'b0, 32'h0, 4'h0, rd, er);
        chk("post_rst_pending", rd, 32'h0);
        do_access(48'h4000_0074, 1'b0, 32'h0, 4'h0, rd, er);
        chk("post_rst_irq_en", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
